// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester handshakes plus the SRAM command/return
// signals shared between the arbiter (slave) and its environment (master).
// The environment side owns both requesters and the SRAM device itself.
// SRAM_ARB_LOCK_EN adds the lock_u/lock_s packet-lock inputs.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req_u;
    logic              we_u;
    logic [ADDR_W-1:0] addr_u;
    logic [DATA_W-1:0] wdata_u;
    logic              gnt_u;
    logic              rvalid_u;

    logic              req_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              gnt_s;
    logic              rvalid_s;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_i;
    logic              sram_wen;
    logic              sram_ren;
    logic [DATA_W-1:0] sram_o;

`ifdef SRAM_ARB_LOCK_EN
    logic              lock_u;
    logic              lock_s;

    modport master (
        output req_u, we_u, addr_u, wdata_u, lock_u,
        output req_s, we_s, addr_s, wdata_s, lock_s,
        output sram_o,
        input  gnt_u, rvalid_u, gnt_s, rvalid_s, rdata,
        input  sram_addr, sram_i, sram_wen, sram_ren
    );

    modport slave (
        input  req_u, we_u, addr_u, wdata_u, lock_u,
        input  req_s, we_s, addr_s, wdata_s, lock_s,
        input  sram_o,
        output gnt_u, rvalid_u, gnt_s, rvalid_s, rdata,
        output sram_addr, sram_i, sram_wen, sram_ren
    );
`else
    modport master (
        output req_u, we_u, addr_u, wdata_u,
        output req_s, we_s, addr_s, wdata_s,
        output sram_o,
        input  gnt_u, rvalid_u, gnt_s, rvalid_s, rdata,
        input  sram_addr, sram_i, sram_wen, sram_ren
    );

    modport slave (
        input  req_u, we_u, addr_u, wdata_u,
        input  req_s, we_s, addr_s, wdata_s,
        input  sram_o,
        output gnt_u, rvalid_u, gnt_s, rvalid_s, rdata,
        output sram_addr, sram_i, sram_wen, sram_ren
    );
`endif

endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one packet SRAM between the USB receive FIFO (U)
// and the SD-card transfer engine (S). Round-robin with a bounded burst,
// one access per cycle, registered SRAM command, read data returned to the
// granted requester two cycles after its grant.
// Optional feature macro: SRAM_ARB_LOCK_EN (lock_u/lock_s suspend the burst
// limit for the current owner so a whole packet stays atomic).
module sram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_U = 2'd1,
        OWN_S = 2'd2
    } state_t;

    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  burst_cnt;
    logic              last_owner_s;   // 1 when S was granted most recently

    logic              pick_u;
    logic              pick_s;
    logic              pick_any;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    state_t            pick_state;
    logic              under_limit;
    logic              lock_u;
    logic              lock_s;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic              ren_q;
    logic              rd_to_s_q;      // owner of the read currently on the SRAM
    logic              rvalid_u_q;
    logic              rvalid_s_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef SRAM_ARB_LOCK_EN
    assign lock_u = bus.lock_u;
    assign lock_s = bus.lock_s;
`else
    assign lock_u = 1'b0;
    assign lock_s = 1'b0;
`endif

    assign under_limit = (burst_cnt < BURST_MAX);

    // Grant decision: current owner keeps the port until its burst is used up
    // while the other side waits; from IDLE a tie goes to the other requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case leaves a value unassigned (no latch).
        pick_u = 1'b0;
        pick_s = 1'b0;
        case (state)
            OWN_U: begin
                if (bus.req_u && (!bus.req_s || under_limit || lock_u)) begin
                    pick_u = 1'b1;
                end else if (bus.req_s) begin
                    pick_s = 1'b1;
                end
            end
            OWN_S: begin
                if (bus.req_s && (!bus.req_u || under_limit || lock_s)) begin
                    pick_s = 1'b1;
                end else if (bus.req_u) begin
                    pick_u = 1'b1;
                end
            end
            default: begin
                if (bus.req_u && bus.req_s) begin
                    pick_u = last_owner_s;
                    pick_s = !last_owner_s;
                end else begin
                    pick_u = bus.req_u;
                    pick_s = bus.req_s;
                end
            end
        endcase
    end

    assign pick_any   = pick_u || pick_s;
    assign pick_state = pick_s ? OWN_S : OWN_U;
    assign pick_we    = pick_s ? bus.we_s    : bus.we_u;
    assign pick_addr  = pick_s ? bus.addr_s  : bus.addr_u;
    assign pick_wdata = pick_s ? bus.wdata_s : bus.wdata_u;

    // Grants are combinational but forced low while reset is asserted.
    assign bus.gnt_u = pick_u && !rst;
    assign bus.gnt_s = pick_s && !rst;

    // Arbitration state plus the registered SRAM command for this cycle's grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            last_owner_s <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            rd_to_s_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here sees the values from before the clock edge.
            if (pick_any) begin
                state        <= pick_state;
                last_owner_s <= pick_s;
                if (state == pick_state) begin
                    burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_ONE;
                end else begin
                    burst_cnt <= CNT_ONE;
                end
                addr_q    <= pick_addr;
                wdata_q   <= pick_wdata;
                wen_q     <= pick_we;
                ren_q     <= !pick_we;
                rd_to_s_q <= pick_s;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
                wen_q     <= 1'b0;
                ren_q     <= 1'b0;
            end
        end
    end

    // Read return: capture SRAM data during the read strobe cycle and flag it
    // to the requester that issued the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_u_q <= 1'b0;
            rvalid_s_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rvalid_u_q <= ren_q && !rd_to_s_q;
            rvalid_s_q <= ren_q && rd_to_s_q;
            if (ren_q) begin
                rdata_q <= bus.sram_o;
            end
        end
    end

    assign bus.sram_addr = addr_q;
    assign bus.sram_i    = wdata_q;
    assign bus.sram_wen  = wen_q;
    assign bus.sram_ren  = ren_q;
    assign bus.rvalid_u  = rvalid_u_q;
    assign bus.rvalid_s  = rvalid_s_q;
    assign bus.rdata     = rdata_q;

endmodule
